mult_param_seq: RTL and testbench
=================================

MULT_PARAM_SEQ -- requirements
Module: mult_param_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; SHALL be a multiple of CHUNK with WIDTH/CHUNK >= 2.
REQ-002 Parameter CHUNK, default 8, width of the partial-product multiplier in bits.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin a multiplication.
REQ-006 a  input  WIDTH  multiplicand.
REQ-007 b  input  WIDTH  multiplier.
REQ-008 signed_mode  input  1  treat a and b as two's complement; present only when MULT_SIGNED_EN is defined.
REQ-009 busy  output  1  operation in progress.
REQ-010 done  output  1  single-cycle pulse when the product is final.
REQ-011 product  output  2*WIDTH  result register.

Function
REQ-012 States: IDLE, CALC. Start is accepted on a rising edge when the state is IDLE and start=1; in CALC, start SHALL be ignored.
REQ-013 On acceptance, the block SHALL latch a, b and signed_mode, clear product to 0, and enter CALC, so that busy=1 from the next cycle.
REQ-014 N=WIDTH/CHUNK; for each operand magnitude, the effective chunk count SHALL be the index of the highest non-zero chunk plus 1, with a minimum of 1 (na, nb).
REQ-015 CALC SHALL process exactly one chunk pair (i,j), i<na, j<nb, per cycle, adding a_i*b_j shifted left by (i+j)*CHUNK into product; busy SHALL be high for exactly na*nb cycles.
REQ-016 Pair order is i outer, j inner; the counters SHALL wrap j to 0 and increment i when j=nb-1.
REQ-017 On the cycle after the last pair, busy=0, done=1 for one cycle, state=IDLE, and product equals the final value.
REQ-018 product SHALL hold its value until the next accepted start or reset.
REQ-019 Arithmetic SHALL be unsigned at full 2*WIDTH width; no overflow is possible.
REQ-020 A start in the same cycle that done=1 SHALL be accepted, which gives back-to-back operation.

Reset
REQ-021 reset=0 SHALL force state=IDLE, busy=0, done=0, product=0 and clear the counters, asynchronously, including in the middle of an operation.
REQ-022 The first start after reset is released SHALL be accepted normally; the aborted operation SHALL leave no residue.

Configuration
REQ-023 Macro MULT_SIGNED_EN.
REQ-024 Defined: when signed_mode=1, the operands are converted to magnitudes before the chunk-count and accumulation steps, and the final product is negated in the last CALC cycle if the operand signs differ; the most-negative operand SHALL be handled correctly.
REQ-025 Undefined: the signed_mode port is absent, all operation is unsigned, and no sign logic is present.

Verification
REQ-026 a=212533089, b=382621682, unsigned -> busy 16 cycles (CHUNK=8), done pulse, product=81319767993835698.
REQ-027 a=62305, b=24306 -> busy 4 cycles, product=1514385330; start held high through done -> second run begins immediately.
REQ-028 a=0, b=0xFFFFFFFF -> busy 4 cycles (na=1, nb=4), product=0.
REQ-029 MULT_SIGNED_EN, signed_mode=1, a=0xFFFFFFFD, b=5 -> busy 1 cycle, product=0xFFFFFFFFFFFFFFF1; same inputs with signed_mode=0 -> busy 4 cycles, product=0x4FFFFFFF1.
REQ-030 Start a=212533089, b=382621682; drive reset=0 at CALC cycle 5 -> busy=0, product=0, done=0 with no clock edge; after reset is released, start a=3, b=7 -> busy 1 cycle, product=21.
REQ-031 Pulse start again during busy with different operands -> ignored; the original product and latency are unchanged.

Source files
------------

// File: rtl/mult_param_seq_if.sv
// Operand/result bundle for mult_param_seq.
// The signed_mode signal exists only when MULT_SIGNED_EN is defined.
interface mult_param_seq_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
`ifdef MULT_SIGNED_EN
  logic               signed_mode;
`endif
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

`ifdef MULT_SIGNED_EN
  modport master (output start, a, b, signed_mode, input busy, done, product);
  modport slave  (input start, a, b, signed_mode, output busy, done, product);
`else
  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
`endif
endinterface

// File: rtl/mult_param_seq.sv
// Sequential multiplier that accumulates one CHUNK x CHUNK partial product per cycle.
// Only the non-zero chunk range is visited. MULT_SIGNED_EN adds two's-complement support.
module mult_param_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            reset,
  mult_param_seq_if.slave bus
);
  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, CALC} state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [IDX_W-1:0]   i_cnt;
  logic [IDX_W-1:0]   j_cnt;
  logic [IDX_W-1:0]   i_last;
  logic [IDX_W-1:0]   j_last;
  logic [2*CHUNK-1:0] pp;
  logic [2*WIDTH-1:0] term;
  logic [2*WIDTH-1:0] sum;
  logic [2*WIDTH-1:0] final_value;
  logic [2*WIDTH-1:0] product_reg;
  logic               done_reg;
  logic               accept;
  logic               last_pair;

  // Index of the highest non-zero chunk, or 0 when the operand is zero.
  function automatic logic [IDX_W-1:0] top_chunk(input logic [WIDTH-1:0] v);
    top_chunk = '0;
    for (int k = 1; k < N; k++) begin
      if (v[k*CHUNK +: CHUNK] != '0) top_chunk = IDX_W'(k);
    end
  endfunction

`ifdef MULT_SIGNED_EN
  logic negate;

  // Magnitudes are unsigned, so the most-negative value maps to 2**(WIDTH-1) cleanly.
  assign a_mag       = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag       = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign final_value = negate ? -sum : sum;
`else
  assign a_mag       = bus.a;
  assign b_mag       = bus.b;
  assign final_value = sum;
`endif

  assign accept    = (state == IDLE) && bus.start;
  assign last_pair = (state == CALC) && (i_cnt == i_last) && (j_cnt == j_last);

  assign pp   = {{CHUNK{1'b0}}, a_reg[int'(i_cnt)*CHUNK +: CHUNK]} *
                {{CHUNK{1'b0}}, b_reg[int'(j_cnt)*CHUNK +: CHUNK]};
  assign term = {{(2*WIDTH-2*CHUNK){1'b0}}, pp} << ((int'(i_cnt) + int'(j_cnt)) * CHUNK);
  assign sum  = product_reg + term;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    if (last_pair) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // done is cleared by default so it only ever pulses for a single cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg       <= '0;
      b_reg       <= '0;
      i_cnt       <= '0;
      j_cnt       <= '0;
      i_last      <= '0;
      j_last      <= '0;
      product_reg <= '0;
      done_reg    <= 1'b0;
`ifdef MULT_SIGNED_EN
      negate      <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        a_reg       <= a_mag;
        b_reg       <= b_mag;
        i_last      <= top_chunk(a_mag);
        j_last      <= top_chunk(b_mag);
        i_cnt       <= '0;
        j_cnt       <= '0;
        product_reg <= '0;
`ifdef MULT_SIGNED_EN
        negate      <= bus.signed_mode && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
`endif
      end else if (state == CALC) begin
        if (last_pair) begin
          product_reg <= final_value;
          done_reg    <= 1'b1;
          i_cnt       <= '0;
          j_cnt       <= '0;
        end else begin
          product_reg <= sum;
          if (j_cnt == j_last) begin
            j_cnt <= '0;
            i_cnt <= i_cnt + 1'b1;
          end else begin
            j_cnt <= j_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign bus.busy    = (state == CALC);
  assign bus.done    = done_reg;
  assign bus.product = product_reg;
endmodule

// File: tb/tb_mult_param_seq.sv
// Self-checking bench for mult_param_seq: vector table, random ops against a model, corner sequences.
// Signed vectors and random signed mode are included when MULT_SIGNED_EN is defined.
module tb_mult_param_seq;
  localparam int WIDTH = 32;
  localparam int CHUNK = 8;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          sm;
    int          lat;
    logic [63:0] prod;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   mode = 1'b0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mult_param_seq_if #(.WIDTH(WIDTH)) bus ();

  mult_param_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] x, input logic [31:0] y);
    bus.a = x;
    bus.b = y;
`ifdef MULT_SIGNED_EN
    bus.signed_mode = mode;
`endif
  endtask

  // Number of chunks needed to hold v, at least one.
  function automatic int model_chunks(input logic [31:0] v);
    int len = 0;
    while (v != 0) begin
      v = v >> 1;
      len++;
    end
    return (len == 0) ? 1 : (len + CHUNK - 1) / CHUNK;
  endfunction

  task automatic model(input logic [31:0] x, input logic [31:0] y, input bit sm,
                       output int lat, output logic [63:0] prod);
    logic [31:0] mx;
    logic [31:0] my;
    if (sm) begin
      mx   = x[31] ? 32'd0 - x : x;
      my   = y[31] ? 32'd0 - y : y;
      prod = 64'(longint'($signed(x)) * longint'($signed(y)));
    end else begin
      mx   = x;
      my   = y;
      prod = {32'd0, x} * {32'd0, y};
    end
    lat = model_chunks(mx) * model_chunks(my);
  endtask

  // Counts busy cycles until done shows up, bounded so a stuck DUT cannot hang the run.
  task automatic wait_done(output int lat, output bit to);
    lat = 0;
    for (int c = 0; c < 200 && !bus.done; c++) begin
      if (bus.busy) lat++;
      @(negedge clk);
    end
    to = !bus.done;
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic [63:0] prod, output bit to);
    @(negedge clk);
    apply_stimulus(x, y);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, to);
    prod = bus.product;
  endtask

  initial begin
    int          lat;
    int          elat;
    bit          to;
    logic [63:0] prod;
    logic [63:0] eprod;
    logic [31:0] x;
    logic [31:0] y;

    vecs.push_back('{32'd212533089, 32'd382621682, 1'b0, 16, 64'd81319767993835698});
    vecs.push_back('{32'd62305, 32'd24306, 1'b0, 4, 64'd1514385330});
    vecs.push_back('{32'd0, 32'hFFFFFFFF, 1'b0, 4, 64'd0});
    vecs.push_back('{32'd3, 32'd7, 1'b0, 1, 64'd21});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 16, 64'hFFFFFFFE00000001});
    vecs.push_back('{32'h100, 32'h10000, 1'b0, 6, 64'h1000000});
`ifdef MULT_SIGNED_EN
    vecs.push_back('{32'hFFFFFFFD, 32'd5, 1'b1, 1, 64'hFFFFFFFFFFFFFFF1});
    vecs.push_back('{32'hFFFFFFFD, 32'd5, 1'b0, 4, 64'h4FFFFFFF1});
    vecs.push_back('{32'h80000000, 32'h80000000, 1'b1, 16, 64'h4000000000000000});
    vecs.push_back('{32'h80000000, 32'd1, 1'b1, 4, 64'hFFFFFFFF80000000});
    vecs.push_back('{32'd7, 32'hFFFFFFFF, 1'b1, 1, 64'hFFFFFFFFFFFFFFF9});
`endif

    reset     = 1'b0;
    bus.start = 1'b0;
    apply_stimulus(32'd0, 32'd0);
    repeat (2) @(negedge clk);
    check_output("reset_busy", 64'(bus.busy), 64'd0);
    check_output("reset_done", 64'(bus.done), 64'd0);
    check_output("reset_product", bus.product, 64'd0);
    reset = 1'b1;

    foreach (vecs[k]) begin
      mode = vecs[k].sm;
      run_op(vecs[k].a, vecs[k].b, lat, prod, to);
      check_output($sformatf("vec%0d_timeout", k), 64'(to), 64'd0);
      check_output($sformatf("vec%0d_latency", k), 64'(lat), 64'(vecs[k].lat));
      check_output($sformatf("vec%0d_product", k), prod, vecs[k].prod);
      check_output($sformatf("vec%0d_busy_at_done", k), 64'(bus.busy), 64'd0);
      @(negedge clk);
      check_output($sformatf("vec%0d_done_pulse", k), 64'(bus.done), 64'd0);
      repeat (2) @(negedge clk);
      check_output($sformatf("vec%0d_product_hold", k), bus.product, vecs[k].prod);
    end

    for (int r = 0; r < 40; r++) begin
      x = $urandom & (32'hFFFFFFFF >> (8 * $urandom_range(0, 3)));
      y = $urandom & (32'hFFFFFFFF >> (8 * $urandom_range(0, 3)));
      mode = 1'b0;
`ifdef MULT_SIGNED_EN
      mode = 1'($urandom_range(0, 1));
      if (mode && $urandom_range(0, 1) == 1) x = x | 32'h80000000;
`endif
      model(x, y, mode, elat, eprod);
      run_op(x, y, lat, prod, to);
      check_output($sformatf("rand%0d_timeout", r), 64'(to), 64'd0);
      check_output($sformatf("rand%0d_latency", r), 64'(lat), 64'(elat));
      check_output($sformatf("rand%0d_product", r), prod, eprod);
    end

    // Start held high through done restarts immediately.
    mode = 1'b0;
    @(negedge clk);
    apply_stimulus(32'd62305, 32'd24306);
    bus.start = 1'b1;
    @(negedge clk);
    wait_done(lat, to);
    check_output("b2b_first_latency", 64'(lat), 64'd4);
    check_output("b2b_first_product", bus.product, 64'd1514385330);
    @(negedge clk);
    check_output("b2b_restart_busy", 64'(bus.busy), 64'd1);
    check_output("b2b_restart_cleared", bus.product, 64'd0);
    bus.start = 1'b0;
    wait_done(lat, to);
    check_output("b2b_second_timeout", 64'(to), 64'd0);
    check_output("b2b_second_latency", 64'(lat), 64'd4);
    check_output("b2b_second_product", bus.product, 64'd1514385330);

    // A start pulse during CALC must not disturb the running operation.
    @(negedge clk);
    apply_stimulus(32'd212533089, 32'd382621682);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    for (int c = 0; c < 200 && !bus.done; c++) begin
      if (bus.busy) lat++;
      if (c == 3) begin
        apply_stimulus(32'd3, 32'd7);
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    check_output("ignore_timeout", 64'(!bus.done), 64'd0);
    check_output("ignore_latency", 64'(lat), 64'd16);
    check_output("ignore_product", bus.product, 64'd81319767993835698);
    @(negedge clk);
    check_output("ignore_idle_after", 64'(bus.busy), 64'd0);

    // Asynchronous reset in the middle of CALC, then a clean run.
    @(negedge clk);
    apply_stimulus(32'd212533089, 32'd382621682);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check_output("abort_busy_before", 64'(bus.busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    check_output("abort_busy", 64'(bus.busy), 64'd0);
    check_output("abort_done", 64'(bus.done), 64'd0);
    check_output("abort_product", bus.product, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(32'd3, 32'd7, lat, prod, to);
    check_output("post_reset_timeout", 64'(to), 64'd0);
    check_output("post_reset_latency", 64'(lat), 64'd1);
    check_output("post_reset_product", prod, 64'd21);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
